// File: rtl/axis_frame_capture_pkg.sv
// rtl/axis_frame_capture_pkg.sv - shared types and helpers for the frame capture buffer
// Contents:
//   cap_state_t  - capture FSM state encoding
//   ERR_CNT_W    - width of the tlast error counter
//   addr_width() - RAM address width for a given depth
package axis_frame_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_SKIP,
        ST_CAPTURE,
        ST_DONE
    } cap_state_t;

    localparam int ERR_CNT_W = 16;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axis_frame_capture_if.sv
// rtl/axis_frame_capture_if.sv - AXI-Stream sample bus between a source and the capture buffer
// Signals: tdata[WIDTH], tvalid, tlast (source -> sink), tready (sink -> source)
// Modports: master (source side), slave (sink side)
interface axis_frame_capture_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/capture_sdp_ram.sv
// rtl/capture_sdp_ram.sv - DEPTH x WIDTH simple dual-port RAM with registered read
// Ports:
//   clk, rst              - clock, sync active-high reset (read register only)
//   wr_en_i, wr_addr_i, wr_data_i - write port
//   rd_addr_i, rd_data_o  - read port, 1-cycle latency, old data on read-during-write
module capture_sdp_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is deliberately unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_frame_capture.sv
// rtl/axis_frame_capture.sv - frame-aligned AXI-Stream capture buffer with read-back port
// Ports:
//   clk, rst        - DSP clock, sync active-high reset
//   s_axis          - sample stream (slave modport), never backpressured
//   arm_i, stop_i   - start a capture sequence / end a ring capture at frame end
//   ring_mode_i, skip_frames_i - capture mode and frames to skip, sampled on arm
//   full_o, busy_o, wr_ptr_o   - status
//   rd_addr_i, rd_data_o       - read-back port, 1-cycle latency
// Optional (AXIS_FRAME_CAPTURE_TLAST_CHECK_EN):
//   event_tlast_missing_o, event_tlast_unexpected_o, tlast_err_cnt_o
module axis_frame_capture
    import axis_frame_capture_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 2048,
    parameter int FRAME_LEN = 64,
    parameter int SKIP_WID  = 8,
    localparam int AW       = addr_width(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    axis_frame_capture_if.slave s_axis,
    input  logic                arm_i,
    input  logic                stop_i,
    input  logic                ring_mode_i,
    input  logic [SKIP_WID-1:0] skip_frames_i,
    output logic                full_o,
    output logic                busy_o,
    output logic [AW-1:0]       wr_ptr_o,
    input  logic [AW-1:0]       rd_addr_i,
    output logic [WIDTH-1:0]    rd_data_o
`ifdef AXIS_FRAME_CAPTURE_TLAST_CHECK_EN
    ,
    output logic                 event_tlast_missing_o,
    output logic                 event_tlast_unexpected_o,
    output logic [ERR_CNT_W-1:0] tlast_err_cnt_o
`endif
);

    if (DEPTH < FRAME_LEN || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("DEPTH must be a power of two and at least FRAME_LEN");
    end

    cap_state_t          state_q;
    logic                tready_q;
    logic                ring_q;
    logic                stop_pend_q;
    logic                full_q;
    logic [SKIP_WID-1:0] skip_q;
    logic [AW-1:0]       wr_ptr_q;
    logic                beat_ok;
    logic                wr_en;
    logic                arm_ok;

    assign beat_ok = s_axis.tvalid && tready_q;
    assign wr_en   = beat_ok && (state_q == ST_CAPTURE);
    assign arm_ok  = arm_i && (state_q == ST_IDLE || state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tready_q    <= 1'b0;
            ring_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            full_q      <= 1'b0;
            skip_q      <= '0;
            wr_ptr_q    <= '0;
        end else begin
            tready_q <= 1'b1;
            case (state_q)
                // A tlast beat in the arming cycle is not taken as alignment.
                ST_IDLE, ST_DONE: begin
                    if (arm_i) begin
                        state_q     <= ST_ALIGN;
                        ring_q      <= ring_mode_i;
                        skip_q      <= skip_frames_i;
                        stop_pend_q <= 1'b0;
                        full_q      <= 1'b0;
                        wr_ptr_q    <= '0;
                    end
                end
                ST_ALIGN: begin
                    if (beat_ok && s_axis.tlast) begin
                        state_q <= (skip_q != '0) ? ST_SKIP : ST_CAPTURE;
                    end
                end
                ST_SKIP: begin
                    if (beat_ok && s_axis.tlast) begin
                        skip_q <= skip_q - SKIP_WID'(1);
                        if (skip_q == SKIP_WID'(1)) begin
                            state_q <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (ring_q && stop_i) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (wr_en) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        // All-ones pointer is address DEPTH-1 (DEPTH is a power of two).
                        if (&wr_ptr_q) begin
                            full_q <= 1'b1;
                        end
                        if (!ring_q && (&wr_ptr_q)) begin
                            state_q <= ST_DONE;
                        end else if (ring_q && s_axis.tlast && (stop_pend_q || stop_i)) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_axis.tready = tready_q;
    assign full_o        = full_q;
    assign busy_o        = (state_q == ST_ALIGN) || (state_q == ST_SKIP) || (state_q == ST_CAPTURE);
    assign wr_ptr_o      = wr_ptr_q;

    capture_sdp_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(s_axis.tdata),
        .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o)
    );

`ifdef AXIS_FRAME_CAPTURE_TLAST_CHECK_EN
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [FW-1:0]        fidx_q;
    logic                 miss_q;
    logic                 unexp_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic                 at_end;
    logic                 miss_d;
    logic                 unexp_d;

    // Index counts captured beats only, so it stays on the original frame
    // grid even after a misplaced tlast.
    assign at_end  = (fidx_q == FW'(FRAME_LEN - 1));
    assign miss_d  = wr_en && at_end && !s_axis.tlast;
    assign unexp_d = wr_en && !at_end && s_axis.tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            fidx_q  <= '0;
            miss_q  <= 1'b0;
            unexp_q <= 1'b0;
            err_q   <= '0;
        end else begin
            miss_q  <= miss_d;
            unexp_q <= unexp_d;
            if (arm_ok) begin
                fidx_q <= '0;
                err_q  <= '0;
            end else begin
                if (wr_en) begin
                    fidx_q <= at_end ? '0 : fidx_q + FW'(1);
                end
                if ((miss_d || unexp_d) && (err_q != '1)) begin
                    err_q <= err_q + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign event_tlast_missing_o    = miss_q;
    assign event_tlast_unexpected_o = unexp_q;
    assign tlast_err_cnt_o          = err_q;
`else
    logic unused_arm_ok;
    assign unused_arm_ok = arm_ok;
`endif

endmodule

// File: tb/tb_axis_frame_capture.sv
// tb/tb_axis_frame_capture.sv - directed self-checking bench for axis_frame_capture
module tb_axis_frame_capture;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 256;
    localparam int FRAME_LEN = 64;
    localparam int SKIP_WID  = 8;
    localparam int AW        = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                arm;
    logic                stop;
    logic                ring_mode;
    logic [SKIP_WID-1:0] skip_frames;
    logic                full;
    logic                busy;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_addr;
    logic [WIDTH-1:0]    rd_data;

    int checks = 0;
    int errors = 0;
    int fr, ix, last_at;
    int tready_low = 0;

`ifdef AXIS_FRAME_CAPTURE_TLAST_CHECK_EN
    logic        ev_miss;
    logic        ev_unexp;
    logic [15:0] err_cnt;
    int          n_miss = 0;
    int          n_unexp = 0;
`endif

    axis_frame_capture_if #(.WIDTH(WIDTH)) s_if ();

    axis_frame_capture #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN), .SKIP_WID(SKIP_WID)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis       (s_if),
        .arm_i        (arm),
        .stop_i       (stop),
        .ring_mode_i  (ring_mode),
        .skip_frames_i(skip_frames),
        .full_o       (full),
        .busy_o       (busy),
        .wr_ptr_o     (wr_ptr),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data)
`ifdef AXIS_FRAME_CAPTURE_TLAST_CHECK_EN
        ,
        .event_tlast_missing_o   (ev_miss),
        .event_tlast_unexpected_o(ev_unexp),
        .tlast_err_cnt_o         (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] expw(input int f, input int i);
        return {f[15:0], i[15:0]};
    endfunction

    // Drives the current stream sample for one cycle; arm/stop are one-cycle pulses.
    task automatic beat(input bit v);
        s_if.tdata  = expw(fr, ix);
        s_if.tlast  = (ix == last_at);
        s_if.tvalid = v;
        step();
        if (s_if.tready !== 1'b1) tready_low++;
`ifdef AXIS_FRAME_CAPTURE_TLAST_CHECK_EN
        if (ev_miss === 1'b1) n_miss++;
        if (ev_unexp === 1'b1) n_unexp++;
`endif
        if (v) begin
            if (ix == FRAME_LEN - 1) begin
                ix = 0;
                fr++;
            end else begin
                ix++;
            end
        end
        arm = 1'b0;
        stop = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
    endtask

    task automatic beats(input int n);
        repeat (n) beat(1'b1);
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        rd_addr = a[7:0];
        step();
        d = rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b0; stop = 1'b0; ring_mode = 1'b0; skip_frames = '0;
        rd_addr = '0; s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; last_at = 63;
        repeat (3) step();
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %0b want 0", s_if.tready); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (wr_ptr !== 8'd0) begin errors++; $display("FAIL reset_wr_ptr got %0d want 0", wr_ptr); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        rst = 1'b0;
        step();
        checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready got %0b want 1", s_if.tready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %0b want 0", busy); end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        fr = 0; ix = 0; ring_mode = 1'b0; skip_frames = '0;
        beats(10);
        arm = 1'b1; beat(1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL os_align_busy got %0b want 1", busy); end
        beats(53);
        checks++; if (wr_ptr !== 8'd0) begin errors++; $display("FAIL os_align_wr_ptr got %0d want 0", wr_ptr); end
        beats(255);
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL os_full_early got %0b want 0", full); end
        checks++; if (wr_ptr !== 8'd255) begin errors++; $display("FAIL os_wr_ptr_255 got %0d want 255", wr_ptr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL os_busy_cap got %0b want 1", busy); end
        beat(1'b1);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL os_full got %0b want 1", full); end
        checks++; if (wr_ptr !== 8'd0) begin errors++; $display("FAIL os_wr_ptr_done got %0d want 0", wr_ptr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL os_busy_done got %0b want 0", busy); end
        beats(5);
        checks++; if (wr_ptr !== 8'd0) begin errors++; $display("FAIL os_wr_ptr_hold got %0d want 0", wr_ptr); end
        rd(0, d);   checks++; if (d !== expw(1, 0))  begin errors++; $display("FAIL os_ram0 got %h want %h", d, expw(1, 0)); end
        rd(100, d); checks++; if (d !== expw(2, 36)) begin errors++; $display("FAIL os_ram100 got %h want %h", d, expw(2, 36)); end
        rd(255, d); checks++; if (d !== expw(4, 63)) begin errors++; $display("FAIL os_ram255 got %h want %h", d, expw(4, 63)); end
    endtask

    task automatic test_skip();
        logic [31:0] d;
        fr = 0; ix = 0;
        beats(5);
        skip_frames = 8'd3; arm = 1'b1; beat(1'b1);
        skip_frames = '0;
        beats(58);
        beats(3 * 64);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL skip_busy got %0b want 1", busy); end
        checks++; if (wr_ptr !== 8'd0) begin errors++; $display("FAIL skip_wr_ptr got %0d want 0", wr_ptr); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL skip_full got %0b want 0", full); end
        rd(0, d);  checks++; if (d !== expw(1, 0))  begin errors++; $display("FAIL skip_nowrite0 got %h want %h", d, expw(1, 0)); end
        rd(63, d); checks++; if (d !== expw(1, 63)) begin errors++; $display("FAIL skip_nowrite63 got %h want %h", d, expw(1, 63)); end
        beats(64);
        checks++; if (wr_ptr !== 8'd64) begin errors++; $display("FAIL skip_wr_ptr64 got %0d want 64", wr_ptr); end
        rd(0, d);  checks++; if (d !== expw(4, 0))  begin errors++; $display("FAIL skip_ram0 got %h want %h", d, expw(4, 0)); end
        rd(63, d); checks++; if (d !== expw(4, 63)) begin errors++; $display("FAIL skip_ram63 got %h want %h", d, expw(4, 63)); end
        rd(64, d); checks++; if (d !== expw(2, 0))  begin errors++; $display("FAIL skip_ram64_old got %h want %h", d, expw(2, 0)); end
        beats(192);
        checks++; if (full !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL skip_done full=%0b busy=%0b want 1 0", full, busy); end
        rd(255, d); checks++; if (d !== expw(7, 63)) begin errors++; $display("FAIL skip_ram255 got %h want %h", d, expw(7, 63)); end
    endtask

    task automatic test_ring();
        logic [31:0] d;
        fr = 0; ix = 0;
        ring_mode = 1'b1; arm = 1'b1; beat(1'b1);
        ring_mode = 1'b0;
        beats(29);
        stop = 1'b1; beat(1'b1);
        beats(33);
        beats(255);
        checks++; if (full !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ring_prewrap full=%0b busy=%0b want 0 1", full, busy); end
        beat(1'b1);
        checks++; if (full !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ring_wrap full=%0b busy=%0b want 1 1", full, busy); end
        checks++; if (wr_ptr !== 8'd0) begin errors++; $display("FAIL ring_wrap_ptr got %0d want 0", wr_ptr); end
        beats(384);
        checks++; if (wr_ptr !== 8'd128) begin errors++; $display("FAIL ring_ptr10 got %0d want 128", wr_ptr); end
        beats(20);
        stop = 1'b1; beat(1'b1);
        beats(42);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ring_stop_early got busy %0b want 1", busy); end
        beat(1'b1);
        checks++; if (busy !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL ring_stop busy=%0b full=%0b want 0 1", busy, full); end
        checks++; if (wr_ptr !== 8'd192) begin errors++; $display("FAIL ring_stop_ptr got %0d want 192", wr_ptr); end
        beats(10);
        checks++; if (wr_ptr !== 8'd192) begin errors++; $display("FAIL ring_hold_ptr got %0d want 192", wr_ptr); end
        rd(191, d); checks++; if (d !== expw(11, 63)) begin errors++; $display("FAIL ring_ram191 got %h want %h", d, expw(11, 63)); end
        rd(0, d);   checks++; if (d !== expw(9, 0))   begin errors++; $display("FAIL ring_ram0 got %h want %h", d, expw(9, 0)); end
        rd(192, d); checks++; if (d !== expw(8, 0))   begin errors++; $display("FAIL ring_ram192 got %h want %h", d, expw(8, 0)); end
    endtask

    task automatic test_stop_on_tlast();
        logic [31:0] d;
        fr = 0; ix = 0;
        ring_mode = 1'b1; arm = 1'b1; beat(1'b1);
        ring_mode = 1'b0;
        checks++; if (wr_ptr !== 8'd0 || full !== 1'b0) begin errors++; $display("FAIL rearm_clear wr_ptr=%0d full=%0b want 0 0", wr_ptr, full); end
        beats(63);
        beats(64 + 63);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sot_busy got %0b want 1", busy); end
        stop = 1'b1; beat(1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sot_done got busy %0b want 0", busy); end
        checks++; if (wr_ptr !== 8'd128 || full !== 1'b0) begin errors++; $display("FAIL sot_ptr wr_ptr=%0d full=%0b want 128 0", wr_ptr, full); end
        rd(127, d); checks++; if (d !== expw(2, 63)) begin errors++; $display("FAIL sot_ram127 got %h want %h", d, expw(2, 63)); end
    endtask

    task automatic test_gaps();
        logic [31:0] d;
        int guard;
        fr = 0; ix = 0; ring_mode = 1'b0; guard = 0;
        while (ix < 10 && guard < 5000) begin beat(1'($urandom_range(0, 1))); guard++; end
        arm = 1'b1; beat(1'($urandom_range(0, 1)));
        while (fr < 5 && guard < 5000) begin beat(1'($urandom_range(0, 1))); guard++; end
        checks++; if (guard >= 5000) begin errors++; $display("FAIL gaps_guard got %0d beats want < 5000", guard); end
        checks++; if (full !== 1'b1 || busy !== 1'b0 || wr_ptr !== 8'd0) begin
            errors++; $display("FAIL gaps_done full=%0b busy=%0b wr_ptr=%0d want 1 0 0", full, busy, wr_ptr); end
        rd(0, d);   checks++; if (d !== expw(1, 0))  begin errors++; $display("FAIL gaps_ram0 got %h want %h", d, expw(1, 0)); end
        rd(100, d); checks++; if (d !== expw(2, 36)) begin errors++; $display("FAIL gaps_ram100 got %h want %h", d, expw(2, 36)); end
        rd(200, d); checks++; if (d !== expw(4, 8))  begin errors++; $display("FAIL gaps_ram200 got %h want %h", d, expw(4, 8)); end
        rd(255, d); checks++; if (d !== expw(4, 63)) begin errors++; $display("FAIL gaps_ram255 got %h want %h", d, expw(4, 63)); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        fr = 0; ix = 0; ring_mode = 1'b0;
        arm = 1'b1; beat(1'b1);
        beats(63);
        beats(100);
        checks++; if (wr_ptr !== 8'd100) begin errors++; $display("FAIL rmid_ptr got %0d want 100", wr_ptr); end
        rst = 1'b1; step();
        checks++; if (busy !== 1'b0 || full !== 1'b0 || wr_ptr !== 8'd0) begin
            errors++; $display("FAIL rmid_clear busy=%0b full=%0b wr_ptr=%0d want 0 0 0", busy, full, wr_ptr); end
        checks++; if (s_if.tready !== 1'b0 || rd_data !== 32'd0) begin
            errors++; $display("FAIL rmid_outs tready=%0b rd_data=%h want 0 0", s_if.tready, rd_data); end
        rst = 1'b0; step();
        fr = 20; ix = 0;
        arm = 1'b1; beat(1'b1);
        beats(63);
        beats(256);
        checks++; if (full !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmid_recap full=%0b busy=%0b want 1 0", full, busy); end
        rd(0, d);   checks++; if (d !== expw(21, 0))  begin errors++; $display("FAIL rmid_ram0 got %h want %h", d, expw(21, 0)); end
        rd(255, d); checks++; if (d !== expw(24, 63)) begin errors++; $display("FAIL rmid_ram255 got %h want %h", d, expw(24, 63)); end
    endtask

`ifdef AXIS_FRAME_CAPTURE_TLAST_CHECK_EN
    task automatic test_tlast_check();
        fr = 0; ix = 0; ring_mode = 1'b0; n_miss = 0; n_unexp = 0;
        arm = 1'b1; beat(1'b1);
        beats(63);
        beats(64);
        last_at = 62; beats(64); last_at = 63;
        beats(128);
        checks++; if (n_unexp != 1) begin errors++; $display("FAIL tchk_unexpected got %0d want 1", n_unexp); end
        checks++; if (n_miss != 1) begin errors++; $display("FAIL tchk_missing got %0d want 1", n_miss); end
        checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL tchk_cnt got %0d want 2", err_cnt); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL tchk_full got %0b want 1", full); end
        arm = 1'b1; beat(1'b0);
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL tchk_clear got %0d want 0", err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_oneshot();
        test_skip();
        test_ring();
        test_stop_on_tlast();
        test_gaps();
        test_reset_mid();
`ifdef AXIS_FRAME_CAPTURE_TLAST_CHECK_EN
        test_tlast_check();
`endif
        checks++; if (tready_low != 0) begin errors++; $display("FAIL tready_const got %0d low cycles want 0", tready_low); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_frame_capture.md
Name: axis_frame_capture

Overview:
- Parametrised on-chip AXI-Stream capture buffer, the successor to the fixed one-shot simulation capture RAM at the OSPFB output.
- Sinks OSPFB output frames into a DEPTH-word RAM.
- Adds frame-aligned arming, frame skipping, one-shot or ring (wrap) mode, and a synchronous read-back port so benches and hardware can dump a capture.
- Sits after the OSPFB/FFT output on the DSP clock.

Parameters:
WIDTH, 32, tdata width in bits (2*sample width for complex data)
DEPTH, 2048, capture RAM words; power of two, >= FRAME_LEN
FRAME_LEN, 64, samples per frame (FFT_LEN); tlast expected on last sample
SKIP_WID, 8, width of the skip_frames count

Ports:
clk  in  1  DSP clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  WIDTH  sample data
s_axis_tvalid  in  1  sample valid
s_axis_tready  out  1  sink ready
s_axis_tlast  in  1  last sample of frame
arm  in  1  single-cycle pulse; starts a capture sequence
stop  in  1  single-cycle pulse; ends ring-mode capture
ring_mode  in  1  0 = one-shot, 1 = wrap continuously; sampled on arm
skip_frames  in  SKIP_WID  whole frames discarded before capture; sampled on arm
full  out  1  RAM holds DEPTH valid words
busy  out  1  state not IDLE/DONE
wr_ptr  out  $clog2(DEPTH)  next write address
rd_addr  in  $clog2(DEPTH)  read address
rd_data  out  WIDTH  RAM word at rd_addr, registered, 1-cycle latency

Behaviour:
- Reset values: s_axis_tready=0, full=0, busy=0, wr_ptr=0, rd_data=0, state=IDLE. In the cycle after rst deasserts, s_axis_tready=1 and stays 1; the block never backpressures.
- A beat is accepted when tvalid && tready.
- FSM states: IDLE, ALIGN, SKIP, CAPTURE, DONE.
- IDLE: arm -> ALIGN. Latch ring_mode and skip_frames; clear wr_ptr and full.
- ALIGN: discard beats until a beat with tlast is accepted. Then go to SKIP if the latched skip count != 0, else to CAPTURE. The first captured word is therefore always frame sample 0.
- SKIP: decrement the skip count on each accepted tlast beat; at 0 go to CAPTURE. No writes occur.
- CAPTURE: each accepted beat writes tdata at wr_ptr; wr_ptr increments modulo DEPTH.
  - One-shot: the write to address DEPTH-1 sets full=1 on the next cycle and moves to DONE; further beats are dropped.
  - Ring: wr_ptr wraps to 0 and full=1 after the first wrap. On stop, the capture finishes the current frame (through the next accepted tlast, inclusive) and then moves to DONE.
- DONE: holds RAM, full and wr_ptr; arm -> ALIGN, restarting the sequence.
- arm while busy: ignored. stop outside ring CAPTURE: ignored.
- Same cycle as a tlast beat:
  - stop plus that tlast beat: the beat is written and the FSM goes to DONE.
  - arm in IDLE/DONE plus that tlast beat: the beat is not counted as alignment. ALIGN starts next cycle.
- The read port is independent of the FSM. rd_data updates every cycle, including during capture (read-during-write to the same address returns old data).
- rst mid-capture: FSM to IDLE, flags cleared. RAM contents are undefined and not cleared.
- Out-of-place tlast does not change alignment after ALIGN; capture counts beats only.

Optional Feature:
- Macro: AXIS_FRAME_CAPTURE_TLAST_CHECK_EN.
- When defined:
  - Adds outputs event_tlast_missing and event_tlast_unexpected (1-cycle pulses) and tlast_err_cnt (16 bits, saturating, cleared on arm).
  - From the first CAPTURE beat, a frame counter modulo FRAME_LEN flags tlast absent at index FRAME_LEN-1 (missing) or present elsewhere (unexpected).
- When undefined: the ports are absent and there is no checking logic.

Decomposition:
- Package axis_frame_capture_pkg holds:
  - the state enum typedef (cap_state_t);
  - the function for the address width ($clog2(DEPTH));
  - a localparam for the error-counter width.
- One sub-module, capture_sdp_ram: simple dual-port RAM, one write port and one registered read port, DEPTH x WIDTH, inferred.

Test Plan:
- One-shot, DEPTH=256, FRAME_LEN=64, skip_frames=0, ramp data with arm mid-frame at sample 10 -> discards 54 samples, RAM[0]=frame sample 0, full rises after 256 accepted beats, wr_ptr=0, busy=0.
- skip_frames=3, frame index encoded in data -> RAM[0] holds the first sample of the 4th complete frame after alignment; no writes during SKIP.
- Ring mode, 10 frames then stop mid-frame 11 -> capture ends at the frame-11 tlast, full=1, wr_ptr=(11*64) mod 256=192, RAM[191] = last sample of frame 11.
- tvalid toggled randomly at 50% -> contents identical to the gapless run; tready constantly 1.
- rst asserted during CAPTURE at beat 100 -> next cycle state=IDLE, full=0, busy=0, wr_ptr=0; re-arm captures correctly.
- With AXIS_FRAME_CAPTURE_TLAST_CHECK_EN, tlast moved to sample 62 in one frame -> one event_tlast_unexpected and one event_tlast_missing, tlast_err_cnt=2.
